neuron_pe: RTL and testbench

NEURON_PE -- requirements
Module: neuron_pe

---
 rtl/neuron_pe.sv | 259 +++++++++++++++++++++++++
 tb/tb_neuron_pe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_pe.sv
// ---------------------------------------------------------------------------
// neuron_pe -- single fixed-point neuron with forward and backward passes.
//
// A weight store (bias + N weights) feeds LANES parallel multiply lanes.
// A forward pass accumulates bias + sum(x[i]*w[i]) over K = ceil(N/LANES)
// cycles and applies the selected activation. A backward pass forms the
// local gradient from the downstream gradient and weight, gates it by the
// activation derivative at the last pre-activation z, and then updates the
// bias and weights in place over K cycles.
// All products are Q(BITS-FRAC).FRAC, shifted by FRAC and saturated; all
// additions saturate to the signed BITS-bit range.
//
// Build option:
//   NEURON_LEAKY_EN  defined   -> act_sel=10 is leaky ReLU (negative z >>> 3)
//                    undefined -> act_sel=10 behaves as plain ReLU
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_w          pulse: copy w and b into the weight store (IDLE only)
//   start, bp       pulse: begin forward (bp=0) or backward (bp=1) pass
//   act_sel         00 linear, 01 ReLU, 10 leaky ReLU, 11 ReLU
//   x, w, b         packed inputs, initial weights, initial bias
//   dz_in, w_in, lr downstream gradient, downstream weight, learning rate
//   busy, done      status: not idle / one-cycle completion pulse
//   y               registered activation output
//   w_out           weight store: bias in slot 0, w[i] in slot i+1
// ---------------------------------------------------------------------------
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for load_w or start
// FWD_MAC  | accumulate LANES products per cycle, K cycles
// FWD_ACT  | latch z and register y = f(z)
// BWD_GRAD | form gated local gradient dz
// BWD_UPD  | update bias (first cycle) and LANES weights per cycle, K cycles
// DONE     | one-cycle done pulse, back to IDLE

module neuron_pe #(
    parameter int N     = 6,
    parameter int BITS  = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_w,
    input  logic                  start,
    input  logic                  bp,
    input  logic [1:0]            act_sel,
    input  logic [N*BITS-1:0]     x,
    input  logic [N*BITS-1:0]     w,
    input  logic [BITS-1:0]       b,
    input  logic [BITS-1:0]       dz_in,
    input  logic [BITS-1:0]       w_in,
    input  logic [BITS-1:0]       lr,
    output logic                  busy,
    output logic                  done,
    output logic [BITS-1:0]       y,
    output logic [(N+1)*BITS-1:0] w_out
);

    localparam int K  = (N + LANES - 1) / LANES;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef logic signed [BITS-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        FWD_MAC,
        FWD_ACT,
        BWD_GRAD,
        BWD_UPD,
        DONE
    } state_t;

    // Clamp a double-width signed value into the BITS-wide range.
    function automatic word_t sat_narrow(input logic signed [2*BITS-1:0] v);
        logic signed [2*BITS-1:0] hi;
        logic signed [2*BITS-1:0] lo;
        hi = {{(BITS+1){1'b0}}, {(BITS-1){1'b1}}};
        lo = {{(BITS+1){1'b1}}, {(BITS-1){1'b0}}};
        if (v > hi)
            sat_narrow = {1'b0, {(BITS-1){1'b1}}};
        else if (v < lo)
            sat_narrow = {1'b1, {(BITS-1){1'b0}}};
        else
            sat_narrow = v[BITS-1:0];
    endfunction

    // Fixed-point product. Operands are sign-extended to double width so
    // the low 2*BITS bits of the unsigned product equal the signed product.
    function automatic word_t pmul(input word_t a, input word_t c);
        logic signed [2*BITS-1:0] prod;
        prod = $signed({{BITS{a[BITS-1]}}, a} * {{BITS{c[BITS-1]}}, c});
        pmul = sat_narrow(prod >>> FRAC);
    endfunction

    function automatic word_t sadd(input word_t a, input word_t c);
        logic signed [BITS:0] s;
        s = {a[BITS-1], a} + {c[BITS-1], c};
        if (s[BITS] != s[BITS-1])
            sadd = {s[BITS], {(BITS-1){~s[BITS]}}};
        else
            sadd = s[BITS-1:0];
    endfunction

    // Activation applied to v, decided by the sign of z. Used for y = f(z)
    // in the forward pass and for gating the gradient in the backward pass.
    function automatic word_t act_gate(input logic [1:0] a, input logic neg,
                                       input word_t v);
        act_gate = v;
        if (neg && (a != 2'b00)) begin
`ifdef NEURON_LEAKY_EN
            if (a == 2'b10)
                act_gate = v >>> 3;
            else
                act_gate = '0;
`else
            act_gate = '0;
`endif
        end
    endfunction

    state_t         state;
    logic [CW-1:0]  cnt;
    word_t          store [0:N];
    word_t          xr    [0:N-1];
    word_t          acc;
    word_t          z_r;
    word_t          dz_r;
    logic [1:0]     act_r;

    int             step;
    word_t          lane_x  [0:LANES-1];
    word_t          lane_w  [0:LANES-1];
    logic           lane_ok [0:LANES-1];
    word_t          lane_p1 [0:LANES-1];
    word_t          mac_sum;
    word_t          store_nxt [0:N];
    word_t          grad;
    word_t          dz_nxt;

    // The lane multiplier is shared: x*w in the forward pass, x*dz in the
    // backward pass. Tail lanes beyond N stay disabled.
    always_comb begin
        step    = (K - 1) - int'(cnt);
        mac_sum = acc;
        for (int k = 0; k <= N; k++)
            store_nxt[k] = store[k];
        if (cnt == CW'(K - 1))
            store_nxt[0] = sadd(store[0], pmul(word_t'(lr), dz_r));
        for (int l = 0; l < LANES; l++) begin
            lane_x[l]  = '0;
            lane_w[l]  = '0;
            lane_ok[l] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (i == step * LANES + l) begin
                    lane_x[l]  = xr[i];
                    lane_w[l]  = store[i + 1];
                    lane_ok[l] = 1'b1;
                end
            end
            lane_p1[l] = pmul(lane_x[l], (state == FWD_MAC) ? lane_w[l] : dz_r);
            if (lane_ok[l])
                mac_sum = sadd(mac_sum, lane_p1[l]);
            for (int i = 0; i < N; i++) begin
                if (i == step * LANES + l)
                    store_nxt[i + 1] = sadd(store[i + 1],
                                            pmul(word_t'(lr), lane_p1[l]));
            end
        end
        grad   = pmul(word_t'(dz_in), word_t'(w_in));
        dz_nxt = act_gate(act_r, z_r[BITS-1], grad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
            acc   <= '0;
            z_r   <= '0;
            dz_r  <= '0;
            act_r <= '0;
            for (int k = 0; k <= N; k++)
                store[k] <= '0;
            for (int i = 0; i < N; i++)
                xr[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_w) begin
                        store[0] <= b;
                        for (int i = 0; i < N; i++)
                            store[i + 1] <= w[i*BITS +: BITS];
                    end else if (start) begin
                        for (int i = 0; i < N; i++)
                            xr[i] <= x[i*BITS +: BITS];
                        act_r <= act_sel;
                        busy  <= 1'b1;
                        if (bp) begin
                            state <= BWD_GRAD;
                        end else begin
                            state <= FWD_MAC;
                            acc   <= store[0];
                            cnt   <= CW'(K - 1);
                        end
                    end
                end
                FWD_MAC: begin
                    acc <= mac_sum;
                    if (cnt == '0)
                        state <= FWD_ACT;
                    else
                        cnt <= cnt - CW'(1);
                end
                FWD_ACT: begin
                    z_r   <= acc;
                    y     <= act_gate(act_r, acc[BITS-1], acc);
                    state <= DONE;
                    done  <= 1'b1;
                end
                BWD_GRAD: begin
                    dz_r  <= dz_nxt;
                    cnt   <= CW'(K - 1);
                    state <= BWD_UPD;
                end
                BWD_UPD: begin
                    for (int k = 0; k <= N; k++)
                        store[k] <= store_nxt[k];
                    if (cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar k = 0; k <= N; k++) begin : g_wout
            assign w_out[k*BITS +: BITS] = store[k];
        end
    endgenerate

endmodule

// File: tb/tb_neuron_pe.sv
// ---------------------------------------------------------------------------
// tb_neuron_pe -- directed scoreboard bench for neuron_pe (N=6, LANES=2,
// Q8.8). Each issued pass pushes its expected result and start cycle; a
// monitor pops on every done pulse and checks value and latency (K+2).
// ---------------------------------------------------------------------------
module tb_neuron_pe;
    localparam int N     = 6;
    localparam int BITS  = 16;
    localparam int FRAC  = 8;
    localparam int LANES = 2;
    localparam int LAT   = 5;

    logic                  clk     = 1'b0;
    logic                  rst_n   = 1'b0;
    logic                  load_w  = 1'b0;
    logic                  start   = 1'b0;
    logic                  bp      = 1'b0;
    logic [1:0]            act_sel = 2'b00;
    logic [N*BITS-1:0]     x       = '0;
    logic [N*BITS-1:0]     w       = '0;
    logic [BITS-1:0]       b       = '0;
    logic [BITS-1:0]       dz_in   = '0;
    logic [BITS-1:0]       w_in    = '0;
    logic [BITS-1:0]       lr      = '0;
    logic                  busy;
    logic                  done;
    logic [BITS-1:0]       y;
    logic [(N+1)*BITS-1:0] w_out;

    neuron_pe #(.N(N), .BITS(BITS), .FRAC(FRAC), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .load_w(load_w), .start(start), .bp(bp),
        .act_sel(act_sel), .x(x), .w(w), .b(b), .dz_in(dz_in), .w_in(w_in),
        .lr(lr), .busy(busy), .done(done), .y(y), .w_out(w_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    string                 name_q[$];
    bit                    bwd_q[$];
    logic [BITS-1:0]       y_q[$];
    logic [(N+1)*BITS-1:0] w_q[$];
    int                    t0_q[$];

    function automatic logic [N*BITS-1:0] fill(input logic [BITS-1:0] v);
        return {N{v}};
    endfunction

    function automatic logic [(N+1)*BITS-1:0] store_of(input logic [BITS-1:0] wv,
                                                       input logic [BITS-1:0] bv);
        return {fill(wv), bv};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        string           nm;
        bit              isb;
        logic [BITS-1:0] ey;
        logic [(N+1)*BITS-1:0] ew;
        int              t0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (name_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d got done=1 want no done", cyc);
                end else begin
                    nm  = name_q.pop_front();
                    isb = bwd_q.pop_front();
                    ey  = y_q.pop_front();
                    ew  = w_q.pop_front();
                    t0  = t0_q.pop_front();
                    chk({nm, "_latency"}, 128'(cyc - t0), 128'(LAT));
                    if (isb)
                        chk({nm, "_w_out"}, 128'(w_out), 128'(ew));
                    else
                        chk({nm, "_y"}, 128'(y), 128'(ey));
                end
            end
        end
    end

    task automatic wait_quiet();
        int n;
        n = 0;
        while (name_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (name_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s got no done want done within 40 cycles", name_q[0]);
            name_q.delete(); bwd_q.delete(); y_q.delete(); w_q.delete(); t0_q.delete();
        end
    endtask

    task automatic do_load(input logic [BITS-1:0] wv, input logic [BITS-1:0] bv);
        @(negedge clk);
        w = fill(wv);
        b = bv;
        load_w = 1'b1;
        @(negedge clk);
        load_w = 1'b0;
    endtask

    task automatic run(input string nm, input logic bpv, input logic [1:0] a,
                       input logic [N*BITS-1:0] xv, input logic [BITS-1:0] ey,
                       input logic [(N+1)*BITS-1:0] ew);
        @(negedge clk);
        bp = bpv;
        act_sel = a;
        x = xv;
        start = 1'b1;
        name_q.push_back(nm); bwd_q.push_back(bpv); y_q.push_back(ey);
        w_q.push_back(ew); t0_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
        wait_quiet();
    endtask

    logic [(N+1)*BITS-1:0] e_leaky_bwd;
    logic [(N+1)*BITS-1:0] e_lin_bwd;
    logic [BITS-1:0]       e_leaky_y;

    initial begin
`ifdef NEURON_LEAKY_EN
        e_leaky_y   = 16'hFF40;
        e_leaky_bwd = store_of(16'hFF10, 16'h0010);
        e_lin_bwd   = store_of(16'hFF90, 16'h0090);
`else
        e_leaky_y   = 16'h0000;
        e_leaky_bwd = store_of(16'hFF00, 16'h0000);
        e_lin_bwd   = store_of(16'hFF80, 16'h0080);
`endif
        #3;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_y", 128'(y), 128'(0));
        chk("reset_w_out", 128'(w_out), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic forward / backward
        do_load(16'h0080, 16'h0100);
        chk("load_w_out", 128'(w_out), 128'(store_of(16'h0080, 16'h0100)));
        run("fwd_relu", 1'b0, 2'b01, fill(16'h0100), 16'h0400, '0);
        dz_in = 16'h0100; w_in = 16'h0100; lr = 16'h0080;
        run("bwd_relu_pos", 1'b1, 2'b01, fill(16'h0100), '0, store_of(16'h0100, 16'h0180));

        // Negative pre-activation under each activation
        do_load(16'hFF00, 16'h0000);
        run("fwd_neg_relu", 1'b0, 2'b01, fill(16'h0100), 16'h0000, '0);
        run("fwd_neg_linear", 1'b0, 2'b00, fill(16'h0100), 16'hFA00, '0);
        run("fwd_neg_leaky", 1'b0, 2'b10, fill(16'h0100), e_leaky_y, '0);
        run("fwd_neg_relu11", 1'b0, 2'b11, fill(16'h0100), 16'h0000, '0);
        run("bwd_neg_relu", 1'b1, 2'b01, fill(16'h0100), '0, store_of(16'hFF00, 16'h0000));
        run("bwd_neg_leaky", 1'b1, 2'b10, fill(16'h0100), '0, e_leaky_bwd);
        run("bwd_neg_linear", 1'b1, 2'b00, fill(16'h0100), '0, e_lin_bwd);

        // Saturation, both directions
        do_load(16'h7F00, 16'h0000);
        run("fwd_sat_pos", 1'b0, 2'b01, fill(16'h7F00), 16'h7FFF, '0);
        do_load(16'h8100, 16'h0000);
        run("fwd_sat_neg", 1'b0, 2'b00, fill(16'h7F00), 16'h8000, '0);

        // load_w wins over a simultaneous start, which is dropped
        @(negedge clk);
        w = fill(16'h0040); b = 16'h0020; bp = 1'b0; act_sel = 2'b00;
        load_w = 1'b1; start = 1'b1;
        @(negedge clk);
        load_w = 1'b0; start = 1'b0;
        chk("load_prio_w_out", 128'(w_out), 128'(store_of(16'h0040, 16'h0020)));
        chk("load_prio_busy", 128'(busy), 128'(0));
        repeat (8) @(negedge clk);

        // start held and load_w pulsed while busy are ignored
        @(negedge clk);
        bp = 1'b0; act_sel = 2'b00; x = fill(16'h0100); start = 1'b1;
        name_q.push_back("fwd_held_start"); bwd_q.push_back(1'b0);
        y_q.push_back(16'h01A0); w_q.push_back('0); t0_q.push_back(cyc);
        @(negedge clk);
        w = fill(16'h7F00); b = 16'h7F00; load_w = 1'b1;
        @(negedge clk);
        load_w = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_quiet();
        chk("busy_load_ignored", 128'(w_out), 128'(store_of(16'h0040, 16'h0020)));
        repeat (8) @(negedge clk);

        // Reset during FWD_MAC cycle 2 aborts with no done
        @(negedge clk);
        bp = 1'b0; act_sel = 2'b00; x = fill(16'h0100); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_y", 128'(y), 128'(0));
        chk("abort_w_out", 128'(w_out), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_idle_busy", 128'(busy), 128'(0));

        // Backward with no forward since reset uses z = 0
        do_load(16'h0080, 16'h0100);
        dz_in = 16'h0100; w_in = 16'h0100; lr = 16'h0080;
        run("bwd_after_reset", 1'b1, 2'b01, fill(16'h0100), '0, store_of(16'h0100, 16'h0180));
        run("fwd_after_reset", 1'b0, 2'b01, fill(16'h0100), 16'h0780, '0);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
